// File: rtl/lane_traffic_ctrl_if.sv
// Bundle between the level/game-state logic (master) and the lane controller (slave).
// The controller reads level/run/frame and returns frame-stable car positions.
interface lane_traffic_ctrl_if #(
    parameter int N_LANES = 4,
    parameter int X_W     = 10
);
    logic [3:0]               i_Level;
    logic                     i_Run;
    logic                     i_Frame_Start;
    logic [N_LANES*X_W-1:0]   o_CarX;
    logic [N_LANES*X_W-1:0]   o_CarY;
    logic [N_LANES-1:0]       o_Wrap;

    modport master (
        output i_Level, i_Run, i_Frame_Start,
        input  o_CarX, o_CarY, o_Wrap
    );

    modport slave (
        input  i_Level, i_Run, i_Frame_Start,
        output o_CarX, o_CarY, o_Wrap
    );
endinterface

// File: rtl/lane_traffic_ctrl.sv
// Multi-lane car mover: per-lane speed counters derived from a frame-sampled level,
// wrapping X positions, and a frame buffer so the renderer sees stable coordinates.
module lane_traffic_ctrl #(
    parameter int                N_LANES    = 4,
    parameter int                GAME_WIDTH = 640,
    parameter int                X_W        = 10,
    parameter int                Y_BASE     = 128,
    parameter int                LANE_PITCH = 32,
    parameter logic [N_LANES-1:0] DIR_MASK  = 4'b0101,
    parameter int                LANE_SKEW  = 5000,
    parameter int                DIV_SHIFT  = 0,
    parameter int                CNT_W      = 18
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    lane_traffic_ctrl_if.slave bus
);

    localparam logic [X_W-1:0] X_MAX = X_W'(GAME_WIDTH - 1);

    logic [3:0]             level_reg;
    logic                   level_change;
    logic [31:0]            base_div;
    logic [N_LANES*X_W-1:0] carx_pack;
    logic [N_LANES*X_W-1:0] cary_pack;
    logic [N_LANES-1:0]     wrap_pack;

    // A new level only takes effect at a frame boundary; a real change restarts every lane's count.
    assign level_change = bus.i_Frame_Start && (bus.i_Level != level_reg);

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            level_reg <= 4'd1;
        end else if (bus.i_Frame_Start) begin
            level_reg <= bus.i_Level;
        end
    end

    always_comb begin
        case (level_reg)
            4'd1:    base_div = 32'd80000;
            4'd2:    base_div = 32'd70000;
            4'd3:    base_div = 32'd60000;
            4'd4:    base_div = 32'd50000;
            4'd5:    base_div = 32'd45000;
            4'd6:    base_div = 32'd40000;
            4'd7:    base_div = 32'd32000;
            4'd8:    base_div = 32'd30000;
            4'd9:    base_div = 32'd15000;
            default: base_div = 32'd80000;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
            localparam logic [31:0]    SKEW_OFS = 32'(gi * LANE_SKEW);
            localparam logic [X_W-1:0] X_INIT   = DIR_MASK[gi] ? '0 : X_MAX;
            localparam logic [X_W-1:0] Y_LANE   = X_W'(Y_BASE + gi * LANE_PITCH);

            logic [CNT_W-1:0] div_lane;
            logic [CNT_W-1:0] cnt_reg, cnt_next;
            logic [X_W-1:0]   x_reg, x_next;
            logic             wrap_reg, wrap_next;
            logic [X_W-1:0]   carx_reg;
            logic [X_W-1:0]   cary_reg;

            // Full-width sum and shift first, then truncate to the counter width.
            assign div_lane = CNT_W'((base_div + SKEW_OFS) >> DIV_SHIFT);

            always_comb begin
                cnt_next  = cnt_reg;
                x_next    = x_reg;
                wrap_next = 1'b0;
                if (level_change) begin
                    cnt_next = '0;
                end else if (bus.i_Run) begin
                    if (cnt_reg < div_lane) begin
                        cnt_next = cnt_reg + 1'b1;
                    end else begin
                        cnt_next = '0;
                        if (DIR_MASK[gi]) begin
                            if (x_reg < X_MAX) begin
                                x_next = x_reg + 1'b1;
                            end else begin
                                x_next    = '0;
                                wrap_next = 1'b1;
                            end
                        end else begin
                            if (x_reg > '0) begin
                                x_next = x_reg - 1'b1;
                            end else begin
                                x_next    = X_MAX;
                                wrap_next = 1'b1;
                            end
                        end
                    end
                end
            end

            always_ff @(posedge i_Clk) begin
                if (!i_Rst_n) begin
                    cnt_reg  <= '0;
                    x_reg    <= X_INIT;
                    wrap_reg <= 1'b0;
                    carx_reg <= X_INIT;
                    cary_reg <= Y_LANE;
                end else begin
                    cnt_reg  <= cnt_next;
                    x_reg    <= x_next;
                    wrap_reg <= wrap_next;
                    // Captures the pre-step position, so a step on this edge shows next frame.
                    if (bus.i_Frame_Start) begin
                        carx_reg <= x_reg;
                    end
                end
            end

            assign carx_pack[gi*X_W +: X_W] = carx_reg;
            assign cary_pack[gi*X_W +: X_W] = cary_reg;
            assign wrap_pack[gi]            = wrap_reg;
        end
    endgenerate

    assign bus.o_CarX = carx_pack;
    assign bus.o_CarY = cary_pack;
    assign bus.o_Wrap = wrap_pack;

endmodule

// File: tb/tb_lane_traffic_ctrl.sv
// Randomized and directed bench for lane_traffic_ctrl against a step-count model
// of each lane (position = start +/- steps mod width).
module tb_lane_traffic_ctrl;
    localparam int NL = 2;
    localparam int W  = 8;
    localparam int XW = 10;
    localparam logic [NL-1:0]      DIRM     = 2'b01;
    localparam logic [NL*XW-1:0]   CARY_EXP = {10'd160, 10'd128};

    logic i_Clk = 1'b0;
    logic i_Rst_n = 1'b0;

    lane_traffic_ctrl_if #(.N_LANES(NL), .X_W(XW)) bus();

    lane_traffic_ctrl #(
        .N_LANES(NL), .GAME_WIDTH(W), .X_W(XW), .Y_BASE(128), .LANE_PITCH(32),
        .DIR_MASK(DIRM), .LANE_SKEW(5000), .DIV_SHIFT(13), .CNT_W(18)
    ) dut (
        .i_Clk(i_Clk),
        .i_Rst_n(i_Rst_n),
        .bus(bus)
    );

    always #5 i_Clk = ~i_Clk;

    int chk  = 0;
    int pass = 0;

    // Model state: level, cycles into the current step period, steps taken mod W.
    int              m_level;
    int              m_phase [NL];
    int              m_steps [NL];
    logic [NL*XW-1:0] m_carx;
    logic [NL-1:0]    m_wrap;

    function automatic int base_of(int lvl);
        case (lvl)
            1: return 80000;  2: return 70000;  3: return 60000;
            4: return 50000;  5: return 45000;  6: return 40000;
            7: return 32000;  8: return 30000;  9: return 15000;
            default: return 80000;
        endcase
    endfunction

    function automatic int lane_div(int lvl, int lane);
        return (base_of(lvl) + lane * 5000) / 8192;
    endfunction

    function automatic int live_x(int lane);
        return DIRM[lane] ? m_steps[lane] : (W - 1 - m_steps[lane]);
    endfunction

    task automatic model_reset();
        m_level = 1;
        m_wrap  = '0;
        for (int i = 0; i < NL; i++) begin
            m_phase[i] = 0;
            m_steps[i] = 0;
            m_carx[i*XW +: XW] = XW'(live_x(i));
        end
    endtask

    // Advance the model by one edge using the inputs currently applied, then clock the DUT.
    task automatic cycle();
        int  divs [NL];
        int  xb   [NL];
        bit  chg;
        for (int i = 0; i < NL; i++) begin
            divs[i] = lane_div(m_level, i);
            xb[i]   = live_x(i);
        end
        if (!i_Rst_n) begin
            model_reset();
        end else begin
            m_wrap = '0;
            chg = bus.i_Frame_Start && (int'(bus.i_Level) != m_level);
            if (bus.i_Frame_Start) begin
                m_level = int'(bus.i_Level);
                for (int i = 0; i < NL; i++) m_carx[i*XW +: XW] = XW'(xb[i]);
            end
            for (int i = 0; i < NL; i++) begin
                if (chg) begin
                    m_phase[i] = 0;
                end else if (bus.i_Run) begin
                    if (m_phase[i] < divs[i]) begin
                        m_phase[i]++;
                    end else begin
                        m_phase[i] = 0;
                        if (( DIRM[i] && xb[i] == W - 1) || (!DIRM[i] && xb[i] == 0))
                            m_wrap[i] = 1'b1;
                        m_steps[i] = (m_steps[i] + 1) % W;
                    end
                end
            end
        end
        @(posedge i_Clk);
        #1;
    endtask

    task automatic do_reset();
        i_Rst_n = 1'b0;
        bus.i_Frame_Start = 1'b0;
        bus.i_Level = 4'd1;
        bus.i_Run = 1'b1;
        repeat (3) cycle();
        i_Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        chk++;
        if (bus.o_CarX !== {10'd7, 10'd0} || bus.o_CarY !== CARY_EXP || bus.o_Wrap !== 2'b00)
            $display("FAIL reset: carx=%h cary=%h wrap=%b, expected carx=%h cary=%h wrap=00",
                     bus.o_CarX, bus.o_CarY, bus.o_Wrap, {10'd7, 10'd0}, CARY_EXP);
        else pass++;
    endtask

    task automatic test_step_rates();
        int wraps0 = 0;
        do_reset();
        bus.i_Frame_Start = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            cycle();
            if (bus.o_Wrap[0] === 1'b1) wraps0++;
            chk++;
            if (bus.o_CarX !== m_carx || bus.o_Wrap !== m_wrap || bus.o_CarY !== CARY_EXP)
                $display("FAIL step_rates c%0d: carx=%h wrap=%b, expected carx=%h wrap=%b",
                         c, bus.o_CarX, bus.o_Wrap, m_carx, m_wrap);
            else pass++;
        end
        cycle();
        if (bus.o_Wrap[0] === 1'b1) wraps0++;
        chk++;
        if (wraps0 !== 1 || bus.o_CarX[XW-1:0] !== 10'd0)
            $display("FAIL step_rates_lap: lane0 wraps=%0d x=%0d, expected wraps=1 x=0",
                     wraps0, bus.o_CarX[XW-1:0]);
        else pass++;
        bus.i_Frame_Start = 1'b0;
    endtask

    task automatic test_frame_buffer();
        do_reset();
        for (int c = 1; c <= 70; c++) begin
            bus.i_Frame_Start = (c == 25 || c == 70);
            cycle();
            chk++;
            if (bus.o_CarX !== m_carx || bus.o_Wrap !== m_wrap)
                $display("FAIL frame_buffer c%0d: carx=%h wrap=%b, expected carx=%h wrap=%b",
                         c, bus.o_CarX, bus.o_Wrap, m_carx, m_wrap);
            else pass++;
            if (c >= 25 && c <= 60) begin
                chk++;
                if (bus.o_CarX[XW-1:0] !== 10'd2)
                    $display("FAIL frame_hold c%0d: lane0=%0d, expected 2", c, bus.o_CarX[XW-1:0]);
                else pass++;
            end
        end
        chk++;
        if (bus.o_CarX[XW-1:0] !== 10'd6)
            $display("FAIL frame_prestep: lane0=%0d, expected 6", bus.o_CarX[XW-1:0]);
        else pass++;
        bus.i_Frame_Start = 1'b0;
    endtask

    task automatic test_level_change();
        bus.i_Level = 4'd9;
        for (int c = 0; c < 45; c++) begin
            // Mid-frame level, then a changing frame pulse, then unchanged pulses every cycle.
            bus.i_Frame_Start = (c >= 25);
            cycle();
            chk++;
            if (bus.o_CarX !== m_carx || bus.o_Wrap !== m_wrap)
                $display("FAIL level_change c%0d: carx=%h wrap=%b, expected carx=%h wrap=%b",
                         c, bus.o_CarX, bus.o_Wrap, m_carx, m_wrap);
            else pass++;
        end
        bus.i_Frame_Start = 1'b0;
    endtask

    task automatic test_pause();
        bus.i_Run = 1'b0;
        for (int c = 0; c < 50; c++) begin
            bus.i_Frame_Start = (c % 7 == 0);
            cycle();
            chk++;
            if (bus.o_Wrap !== 2'b00 || bus.o_CarX !== m_carx)
                $display("FAIL pause c%0d: carx=%h wrap=%b, expected carx=%h wrap=00",
                         c, bus.o_CarX, bus.o_Wrap, m_carx);
            else pass++;
        end
        bus.i_Run = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.i_Frame_Start = 1'b1;
            cycle();
            chk++;
            if (bus.o_CarX !== m_carx || bus.o_Wrap !== m_wrap)
                $display("FAIL resume c%0d: carx=%h wrap=%b, expected carx=%h wrap=%b",
                         c, bus.o_CarX, bus.o_Wrap, m_carx, m_wrap);
            else pass++;
        end
        bus.i_Frame_Start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit found = 0;
        bus.i_Level = 4'd0;
        bus.i_Frame_Start = 1'b1;
        cycle();
        bus.i_Frame_Start = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            if (live_x(0) == W - 1 && m_phase[0] == lane_div(m_level, 0)) found = 1;
            else cycle();
        end
        chk++;
        if (!found) begin
            $display("FAIL reset_mid_run_search: no wrap edge within 200 cycles, expected one");
        end else begin
            pass++;
            i_Rst_n = 1'b0;
            cycle();
            i_Rst_n = 1'b1;
            chk++;
            if (bus.o_Wrap !== 2'b00 || bus.o_CarX !== {10'd7, 10'd0} || bus.o_CarX !== m_carx)
                $display("FAIL reset_mid_run: carx=%h wrap=%b, expected carx=%h wrap=00",
                         bus.o_CarX, bus.o_Wrap, {10'd7, 10'd0});
            else pass++;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            i_Rst_n = ($urandom_range(0, 499) != 0);
            bus.i_Run = ($urandom_range(0, 9) != 0);
            bus.i_Frame_Start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 39) == 0) bus.i_Level = 4'($urandom_range(0, 15));
            cycle();
            chk++;
            if (bus.o_CarX !== m_carx || bus.o_Wrap !== m_wrap || bus.o_CarY !== CARY_EXP)
                $display("FAIL random c%0d: carx=%h wrap=%b cary=%h, expected carx=%h wrap=%b",
                         c, bus.o_CarX, bus.o_Wrap, bus.o_CarY, m_carx, m_wrap);
            else pass++;
        end
        i_Rst_n = 1'b1;
    endtask

    initial begin
        bus.i_Level = 4'd1;
        bus.i_Run = 1'b1;
        bus.i_Frame_Start = 1'b0;
        model_reset();
        test_reset();
        test_step_rates();
        test_frame_buffer();
        test_level_change();
        test_pause();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
